// File: rtl/core_pkg.sv
// core_pkg: shared RV32I opcode constants, loader state encoding and opcode filter
package core_pkg;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    typedef enum logic [2:0] {ST_IDLE, ST_HDR, ST_DATA, ST_WRITE, ST_DONE} loader_state_e;

    function automatic logic opcode_supported(input logic [6:0] opc);
        return opc inside {OPC_RTYPE, OPC_LOAD, OPC_STORE, OPC_BRANCH,
                           OPC_ITYPE, OPC_JALR, OPC_JAL, OPC_LUI};
    endfunction
endpackage

// File: rtl/byte_word_assembler.sv
// byte_word_assembler: packs stream bytes little-endian into a 32-bit word
module byte_word_assembler (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        take_i,
    input  logic [7:0]  byte_i,
    output logic [1:0]  idx_o,
    output logic [31:0] word_o,
    output logic        word_valid_o
);
    logic [1:0]  idx_q, idx_d;
    logic [23:0] data_q, data_d;

    // The 4th byte is never stored: it is presented live on word_o[31:24]
    always_comb begin
        idx_d  = clr_i ? 2'd0 : take_i ? idx_q + 2'd1 : idx_q;
        data_d = (take_i && idx_q != 2'd3)
               ? (data_q & ~(24'hFF << {idx_q, 3'b000})) | (24'(byte_i) << {idx_q, 3'b000})
               : data_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            idx_q  <= 2'd0;
            data_q <= 24'd0;
        end else begin
            idx_q  <= idx_d;
            data_q <= data_d;
        end
    end

    assign idx_o        = idx_q;
    assign word_o       = {byte_i, data_q};
    assign word_valid_o = take_i && idx_q == 2'd3;
endmodule

// File: rtl/imem_program_loader.sv
// imem_program_loader: streams a length-prefixed byte program into imem, holding the core until done.
// Optional LOADER_OPCODE_CHECK_EN aborts the load on a word with an unsupported RV32I opcode.
module imem_program_loader #(
    parameter int IMEM_DEPTH = 256
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          start_i,
    input  logic [7:0]                    byte_i,
    input  logic                          byte_valid_i,
    output logic                          byte_ready_o,
    output logic                          imem_we_o,
    output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr_o,
    output logic [31:0]                   imem_wdata_o,
    output logic                          core_hold_o,
    output logic                          done_o,
    output logic                          err_o,
    output logic [15:0]                   words_o
);
    import core_pkg::*;

    localparam int AW = $clog2(IMEM_DEPTH);

    loader_state_e state_q, state_d;
    logic [15:0]   len_q, len_d, words_q, words_d, hdr_n;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d, word;
    logic          err_q, err_d, take, clr, word_valid, opc_ok;
    logic [1:0]    idx;

    assign take  = byte_valid_i && byte_ready_o;
    assign hdr_n = {word[31:24], word[7:0]};

`ifdef LOADER_OPCODE_CHECK_EN
    assign opc_ok = opcode_supported(wdata_q[6:0]);
`else
    assign opc_ok = 1'b1;
`endif

    byte_word_assembler u_asm (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clr_i        (clr),
        .take_i       (take),
        .byte_i       (byte_i),
        .idx_o        (idx),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        words_d = words_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        clr     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: if (start_i) begin
                state_d = ST_HDR;
                err_d   = 1'b0;
                words_d = 16'd0;
                clr     = 1'b1;
            end
            ST_HDR: if (take && idx == 2'd1) begin
                clr     = 1'b1;
                len_d   = hdr_n;
                err_d   = {1'b0, hdr_n} > 17'(IMEM_DEPTH);
                state_d = (hdr_n == 16'd0 || err_d) ? ST_DONE : ST_DATA;
            end
            ST_DATA: if (word_valid) begin
                state_d = ST_WRITE;
                addr_d  = words_q[AW-1:0];
                wdata_d = word;
            end
            ST_WRITE: if (!opc_ok) begin
                state_d = ST_DONE;
                err_d   = 1'b1;
            end else begin
                words_d = words_q + 16'd1;
                state_d = (words_q + 16'd1 == len_q) ? ST_DONE : ST_DATA;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            len_q   <= 16'd0;
            words_q <= 16'd0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            words_q <= words_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign byte_ready_o = state_q == ST_HDR || state_q == ST_DATA;
    assign imem_we_o    = state_q == ST_WRITE && opc_ok;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign done_o       = state_q == ST_DONE && !err_q;
    assign core_hold_o  = !done_o;
    assign err_o        = err_q;
    assign words_o      = words_q;
endmodule

// File: tb/tb_imem_program_loader.sv
// tb_imem_program_loader: directed checks of the imem program loader
module tb_imem_program_loader;
    logic        clk_i = 1'b0;
    logic        rst_ni, start_i, byte_valid_i;
    logic [7:0]  byte_i;
    logic        byte_ready_o, imem_we_o, core_hold_o, done_o, err_o;
    logic [7:0]  imem_addr_o;
    logic [31:0] imem_wdata_o;
    logic [15:0] words_o;
    int          vectors = 0, fails = 0;
    logic [7:0]  aq[$];
    logic [31:0] dq[$];
    logic [31:0] prog [256];

    imem_program_loader #(.IMEM_DEPTH(256)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .byte_i(byte_i),
        .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o), .imem_we_o(imem_we_o),
        .imem_addr_o(imem_addr_o), .imem_wdata_o(imem_wdata_o), .core_hold_o(core_hold_o),
        .done_o(done_o), .err_o(err_o), .words_o(words_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) if (imem_we_o === 1'b1) begin
        aq.push_back(imem_addr_o);
        dq.push_back(imem_wdata_o);
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running at 1ms, need completion");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        repeat (gap) @(negedge clk_i);
        @(negedge clk_i);
        byte_i = b;
        byte_valid_i = 1'b1;
        while (byte_ready_o !== 1'b1 && t < 20) begin
            @(negedge clk_i);
            t++;
        end
        vectors++;
        if (byte_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL send_byte: byte_ready_o=%b after 20 cycles, need 1", byte_ready_o);
        end
        @(posedge clk_i);
        #1 byte_valid_i = 1'b0;
    endtask

    task automatic send_hdr(input logic [15:0] n);
        send_byte(n[7:0], 0);
        send_byte(n[15:8], 0);
    endtask

    task automatic send_data(input int n, input int maxgap);
        for (int i = 0; i < n; i++)
            for (int k = 0; k < 4; k++)
                send_byte(8'(prog[i] >> (8 * k)), int'($urandom_range(0, maxgap)));
    endtask

    task automatic pulse_start;
        @(negedge clk_i) start_i = 1'b1;
        @(negedge clk_i) start_i = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk_i);
        vectors++;
        if ({byte_ready_o, imem_we_o, core_hold_o, done_o, err_o} !== 5'b00100) begin
            fails++;
            $display("FAIL reset_flags: got rdy/we/hold/done/err=%b need 00100",
                     {byte_ready_o, imem_we_o, core_hold_o, done_o, err_o});
        end
        vectors++;
        if (imem_addr_o !== 8'd0 || imem_wdata_o !== 32'd0 || words_o !== 16'd0) begin
            fails++;
            $display("FAIL reset_data: got addr=%h wdata=%h words=%0d need 0/0/0",
                     imem_addr_o, imem_wdata_o, words_o);
        end
        rst_ni = 1'b1;
    endtask

    task automatic test_basic;
        aq.delete(); dq.delete();
        prog[0] = 32'h00000513;
        prog[1] = 32'h00100093;
        pulse_start();
        send_hdr(16'd2);
        send_data(2, 0);
        vectors++;
        if ({imem_we_o, core_hold_o} !== 2'b11 || imem_addr_o !== 8'd1 || imem_wdata_o !== 32'h00100093) begin
            fails++;
            $display("FAIL basic_write2: got we=%b hold=%b addr=%h wdata=%h need 1 1 01 00100093",
                     imem_we_o, core_hold_o, imem_addr_o, imem_wdata_o);
        end
        @(posedge clk_i); #1;
        vectors++;
        if ({core_hold_o, done_o, err_o, imem_we_o} !== 4'b0100 || words_o !== 16'd2) begin
            fails++;
            $display("FAIL basic_done: got hold/done/err/we=%b words=%0d need 0100 words=2",
                     {core_hold_o, done_o, err_o, imem_we_o}, words_o);
        end
        vectors++;
        if (aq.size() != 2) begin
            fails++;
            $display("FAIL basic_count: got %0d writes need 2", aq.size());
        end
        for (int i = 0; i < aq.size(); i++) begin
            vectors++;
            if (aq[i] !== 8'(i) || dq[i] !== prog[i]) begin
                fails++;
                $display("FAIL basic_word%0d: got addr=%h data=%h need %h %h", i, aq[i], dq[i], 8'(i), prog[i]);
            end
        end
    endtask

    task automatic test_boundary_len;
        aq.delete(); dq.delete();
        pulse_start();
        send_hdr(16'd0);
        vectors++;
        if ({done_o, err_o, core_hold_o} !== 3'b100 || words_o !== 16'd0) begin
            fails++;
            $display("FAIL zero_len: got done/err/hold=%b words=%0d need 100 0",
                     {done_o, err_o, core_hold_o}, words_o);
        end
        @(negedge clk_i);
        byte_i = 8'hAA;
        byte_valid_i = 1'b1;
        repeat (4) @(negedge clk_i);
        vectors++;
        if (byte_ready_o !== 1'b0 || words_o !== 16'd0 || done_o !== 1'b1) begin
            fails++;
            $display("FAIL done_ignores: got ready=%b words=%0d done=%b need 0 0 1", byte_ready_o, words_o, done_o);
        end
        byte_valid_i = 1'b0;
        pulse_start();
        send_hdr(16'd257);
        vectors++;
        if ({done_o, err_o, core_hold_o} !== 3'b011 || words_o !== 16'd0) begin
            fails++;
            $display("FAIL oversize: got done/err/hold=%b words=%0d need 011 0",
                     {done_o, err_o, core_hold_o}, words_o);
        end
        repeat (2) @(negedge clk_i);
        vectors++;
        if (aq.size() != 0) begin
            fails++;
            $display("FAIL boundary_nowrite: got %0d writes need 0", aq.size());
        end
    endtask

    task automatic test_gaps;
        aq.delete(); dq.delete();
        prog[0] = 32'h00000513;
        prog[1] = 32'h00100093;
        prog[2] = 32'h00208133;
        pulse_start();
        send_hdr(16'd3);
        send_data(3, 2);
        @(posedge clk_i); #1;
        vectors++;
        if (aq.size() != 3 || done_o !== 1'b1 || words_o !== 16'd3) begin
            fails++;
            $display("FAIL gaps_done: got writes=%0d done=%b words=%0d need 3 1 3", aq.size(), done_o, words_o);
        end
        for (int i = 0; i < aq.size(); i++) begin
            vectors++;
            if (aq[i] !== 8'(i) || dq[i] !== prog[i]) begin
                fails++;
                $display("FAIL gaps_word%0d: got addr=%h data=%h need %h %h", i, aq[i], dq[i], 8'(i), prog[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        prog[0] = 32'h00000513;
        pulse_start();
        send_hdr(16'd3);
        send_data(1, 0);
        rst_ni = 1'b0;
        byte_valid_i = 1'b1;
        @(posedge clk_i); #1;
        aq.delete(); dq.delete();
        vectors++;
        if ({byte_ready_o, imem_we_o, core_hold_o, done_o, err_o} !== 5'b00100 || words_o !== 16'd0
            || imem_addr_o !== 8'd0 || imem_wdata_o !== 32'd0) begin
            fails++;
            $display("FAIL midreset_outputs: got flags=%b words=%0d addr=%h wdata=%h need 00100 0 00 0",
                     {byte_ready_o, imem_we_o, core_hold_o, done_o, err_o}, words_o, imem_addr_o, imem_wdata_o);
        end
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk_i);
        byte_valid_i = 1'b0;
        vectors++;
        if (aq.size() != 0 || core_hold_o !== 1'b1 || words_o !== 16'd0) begin
            fails++;
            $display("FAIL midreset_quiet: got writes=%0d hold=%b words=%0d need 0 1 0", aq.size(), core_hold_o, words_o);
        end
        pulse_start();
        send_hdr(16'd1);
        send_data(1, 0);
        @(posedge clk_i); #1;
        vectors++;
        if (aq.size() != 1 || aq[0] !== 8'd0 || dq[0] !== 32'h00000513 || done_o !== 1'b1) begin
            fails++;
            $display("FAIL midreset_reload: got writes=%0d addr=%h data=%h done=%b need 1 00 00000513 1",
                     aq.size(), aq[0], dq[0], done_o);
        end
    endtask

    task automatic test_opcode;
        aq.delete(); dq.delete();
        prog[0] = 32'h00000513;
        prog[1] = 32'h0000007F;
        pulse_start();
        send_hdr(16'd2);
        send_data(2, 0);
        repeat (2) @(negedge clk_i);
`ifdef LOADER_OPCODE_CHECK_EN
        vectors++;
        if (aq.size() != 1 || {err_o, done_o, core_hold_o} !== 3'b101 || words_o !== 16'd1) begin
            fails++;
            $display("FAIL opcode_abort: got writes=%0d err/done/hold=%b words=%0d need 1 101 1",
                     aq.size(), {err_o, done_o, core_hold_o}, words_o);
        end
`else
        vectors++;
        if (aq.size() != 2 || {err_o, done_o, core_hold_o} !== 3'b010 || words_o !== 16'd2) begin
            fails++;
            $display("FAIL opcode_nocheck: got writes=%0d err/done/hold=%b words=%0d need 2 010 2",
                     aq.size(), {err_o, done_o, core_hold_o}, words_o);
        end
`endif
        vectors++;
        if (aq.size() < 1 || aq[0] !== 8'd0 || dq[0] !== 32'h00000513) begin
            fails++;
            $display("FAIL opcode_word0: got writes=%0d addr=%h data=%h need >=1 00 00000513",
                     aq.size(), aq[0], dq[0]);
        end
    endtask

    task automatic test_full;
        int bad;
        for (int i = 0; i < 256; i++) prog[i] = (32'(i) << 20) | 32'h13;
        for (int pass = 0; pass < 2; pass++) begin
            aq.delete(); dq.delete();
            pulse_start();
            send_hdr(16'd256);
            send_data(256, 0);
            vectors++;
            if (imem_we_o !== 1'b1 || imem_addr_o !== 8'd255 || imem_wdata_o !== 32'h0FF00013) begin
                fails++;
                $display("FAIL full_last%0d: got we=%b addr=%h wdata=%h need 1 ff 0ff00013",
                         pass, imem_we_o, imem_addr_o, imem_wdata_o);
            end
            @(posedge clk_i); #1;
            vectors++;
            if (aq.size() != 256 || done_o !== 1'b1 || core_hold_o !== 1'b0 || words_o !== 16'd256) begin
                fails++;
                $display("FAIL full_done%0d: got writes=%0d done=%b hold=%b words=%0d need 256 1 0 256",
                         pass, aq.size(), done_o, core_hold_o, words_o);
            end
            bad = 0;
            for (int i = 0; i < aq.size(); i++) if (aq[i] !== 8'(i) || dq[i] !== prog[i]) bad++;
            vectors++;
            if (bad != 0) begin
                fails++;
                $display("FAIL full_words%0d: got %0d wrong entries need 0", pass, bad);
            end
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        start_i = 1'b0;
        byte_valid_i = 1'b0;
        byte_i = 8'h00;
        test_reset();
        test_basic();
        test_boundary_len();
        test_gaps();
        test_reset_mid();
        test_opcode();
        test_full();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
